// File: rtl/sd_fifo_word_reader_pkg.sv
// Shared constants for the SD FIFO word reader: FSM encodings and sector geometry.
package sd_fifo_word_reader_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  localparam int SD_SECTOR_BYTES = 512;
  localparam int SD_SECTOR_WORDS = 128;

  typedef logic [1:0] state_t;

endpackage

// File: rtl/sd_fifo_word_reader_packer.sv
// Byte-to-word packer: byte index counter plus lane-select capture register.
module sd_fifo_word_reader_packer #(
  parameter int BYTE_W     = 8,
  parameter int WORD_W     = 32,
  parameter int LITTLE_END = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cap_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [1:0]        idx,
  output logic [WORD_W-1:0] word_out,
  output logic              full
);

  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        lane;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    lane   = (LITTLE_END != 0) ? idx_q : (2'd3 - idx_q);
    full   = cap_en && (idx_q == 2'd3);
    if (clr) begin
      idx_d = '0;
    end else if (cap_en) begin
      word_d[lane*BYTE_W +: BYTE_W] = byte_in;
      // 2-bit index wraps 3 -> 0 on the capture that completes the word
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign idx      = idx_q;
  assign word_out = word_q;

endmodule

// File: rtl/sd_fifo_word_reader.sv
// Drains N 32-bit words from the 8-bit SD FIFO read port onto a valid/ready stream.
module sd_fifo_word_reader
  import sd_fifo_word_reader_pkg::*;
#(
  parameter int BYTE_W     = 8,
  parameter int WORD_W     = 32,
  parameter int LEN_W      = 8,
  parameter int LITTLE_END = 1
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LEN_W-1:0]  req_words,
  output logic              fifo_rd_en,
  input  logic [BYTE_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_empty,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic              busy,
  output logic [LEN_W-1:0]  words_left
);

  if (BYTE_W != 8) begin : g_bad_byte_w
    $error("sd_fifo_word_reader: BYTE_W must be 8");
  end
  if (WORD_W != 4 * BYTE_W) begin : g_bad_word_w
    $error("sd_fifo_word_reader: WORD_W must equal 4*BYTE_W");
  end

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic [LEN_W-1:0] words_left_q, words_left_d;
  logic             word_valid_q, word_valid_d;
  logic             word_last_q, word_last_d;

  logic       pk_clr, pk_cap, pk_full;
  logic [1:0] pk_idx;
  logic [2:0] fill;

  // bytes captured plus the one still in flight must not exceed a word
  assign fill       = {1'b0, pk_idx} + {2'b00, pending_q};
  assign fifo_rd_en = (state_q == ST_FETCH) && !fifo_rd_empty && (fill < 3'd4);
  assign pk_cap     = (state_q == ST_FETCH) && pending_q;
  assign pk_clr     = (state_q == ST_IDLE) && req_valid;

  sd_fifo_word_reader_packer #(
    .BYTE_W(BYTE_W), .WORD_W(WORD_W), .LITTLE_END(LITTLE_END)
  ) u_packer (
    .clk(rd_clk), .rst(rd_rst), .clr(pk_clr), .cap_en(pk_cap),
    .byte_in(fifo_rd_data), .idx(pk_idx), .word_out(word_data), .full(pk_full)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = 1'b0;
    words_left_d = words_left_q;
    word_valid_d = word_valid_q;
    word_last_d  = word_last_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          words_left_d = req_words;
          if (req_words != '0) state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        pending_d   = fifo_rd_en;
        word_last_d = (words_left_q == LEN_W'(1));
        if (pk_full) begin
          word_valid_d = 1'b1;
          state_d      = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (word_ready) begin
          word_valid_d = 1'b0;
          word_last_d  = 1'b0;
          if (words_left_q != '0) words_left_d = words_left_q - LEN_W'(1);
          state_d = word_last_q ? ST_IDLE : ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      words_left_q <= '0;
      word_valid_q <= 1'b0;
      word_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      words_left_q <= words_left_d;
      word_valid_q <= word_valid_d;
      word_last_q  <= word_last_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign word_valid = word_valid_q;
  assign word_last  = word_last_q;
  assign words_left = words_left_q;

endmodule

// File: tb/tb_sd_fifo_word_reader.sv
// Bench: queue-based FIFO model feeding little- and big-endian reader instances.
module tb_sd_fifo_word_reader;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [7:0]  req_words = '0;
  logic        word_ready = 1'b0;
  logic [7:0]  fifo_rd_data = '0;
  logic        fifo_empty = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;

  logic        le_req_ready, le_rd_en, le_valid, le_last, le_busy;
  logic [31:0] le_data;
  logic [7:0]  le_left;
  logic        be_req_ready, be_rd_en, be_valid, be_last, be_busy;
  logic [31:0] be_data;
  logic [7:0]  be_left;

  int errors = 0;
  int checks = 0;
  int rden_cnt = 0;
  int rdy_mode = 0;

  logic [7:0]  fq[$];
  logic [7:0]  sent[$];
  logic [31:0] got_le[$];
  logic [31:0] got_be[$];
  logic        got_last[$];

  always #5 rd_clk = ~rd_clk;

  sd_fifo_word_reader #(.LITTLE_END(1)) u_le (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .req_valid(req_valid), .req_ready(le_req_ready),
    .req_words(req_words), .fifo_rd_en(le_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_empty), .word_data(le_data), .word_valid(le_valid),
    .word_ready(word_ready), .word_last(le_last), .busy(le_busy), .words_left(le_left)
  );

  sd_fifo_word_reader #(.LITTLE_END(0)) u_be (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .req_valid(req_valid), .req_ready(be_req_ready),
    .req_words(req_words), .fifo_rd_en(be_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_empty), .word_data(be_data), .word_valid(be_valid),
    .word_ready(word_ready), .word_last(be_last), .busy(be_busy), .words_left(be_left)
  );

  // FIFO with unregistered output: data appears the cycle after a pop
  always @(posedge rd_clk) begin
    if (rd_rst) begin
      fq.delete();
    end else begin
      if (le_rd_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
    end
    fifo_empty <= (rd_rst || fq.size() == 0);
  end

  always @(posedge rd_clk) begin
    #1;
    word_ready = (rdy_mode == 2) ? ($urandom_range(1, 0) == 1) : (rdy_mode == 1);
  end

  logic        pv = 1'b0, prdy = 1'b0, pl = 1'b0;
  logic [31:0] pd = '0;
  always @(negedge rd_clk) begin
    if (!rd_rst) begin
      if (le_rd_en || be_rd_en) begin
        rden_cnt++;
        checks++;
        if (fifo_empty) begin
          errors++;
          $display("FAIL underflow: rd_en le=%0b be=%0b while empty=%0b, required no pop", le_rd_en, be_rd_en, fifo_empty);
        end
      end
      if (pv && !prdy) begin
        checks++;
        if (!le_valid || le_data !== pd || le_last !== pl) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b data=%08h last=%0b, required valid=1 data=%08h last=%0b", le_valid, le_data, le_last, pd, pl);
        end
      end
      if (le_valid && word_ready) begin
        got_le.push_back(le_data);
        got_last.push_back(le_last);
      end
      if (be_valid && word_ready) got_be.push_back(be_data);
    end
    pv = le_valid; prdy = word_ready; pd = le_data; pl = le_last;
  end

  function automatic logic [31:0] pack(input logic [7:0] b0, b1, b2, b3, input bit le);
    return le ? {b3, b2, b1, b0} : {b0, b1, b2, b3};
  endfunction

  task automatic tick();
    @(posedge rd_clk); #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; sent.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic issue_req(input logic [7:0] n);
    req_valid = 1'b1; req_words = n;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge rd_clk);
      if (!le_busy) begin ok = 1'b1; break; end
    end
    tick();
  endtask

  task automatic clear_got();
    got_le.delete(); got_be.delete(); got_last.delete(); sent.delete();
  endtask

  task automatic test_reset();
    rd_rst = 1'b1;
    tick(); tick();
    @(negedge rd_clk);
    checks++; if (le_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", le_valid); end
    checks++; if (le_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %08h want 0", le_data); end
    checks++; if (le_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %0b want 0", le_last); end
    checks++; if (le_left !== 8'd0) begin errors++; $display("FAIL rst_left: got %0d want 0", le_left); end
    checks++; if (le_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", le_busy); end
    checks++; if (le_req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %0b want 1", le_req_ready); end
    checks++; if (le_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %0b want 0", le_rd_en); end
    tick();
    rd_rst = 1'b0;
    tick();
  endtask

  task automatic test_two_words();
    int lat; bit ok;
    rdy_mode = 1;
    clear_got();
    for (int i = 0; i < 8; i++) write_byte(8'(i));
    tick(); tick();
    req_valid = 1'b1; req_words = 8'd2;
    tick();
    req_valid = 1'b0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge rd_clk);
      if (le_valid) begin lat = k; break; end
    end
    checks++; if (lat != 5) begin errors++; $display("FAIL first_latency: got %0d clocks want 5", lat); end
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL two_idle: busy timeout, want idle"); end
    checks++;
    if (got_le.size() != 2 || got_be.size() != 2) begin
      errors++; $display("FAIL two_count: got le=%0d be=%0d words want 2", got_le.size(), got_be.size());
    end else begin
      for (int w = 0; w < 2; w++) begin
        logic [31:0] e_le, e_be;
        e_le = pack(sent[4*w], sent[4*w+1], sent[4*w+2], sent[4*w+3], 1'b1);
        e_be = pack(sent[4*w], sent[4*w+1], sent[4*w+2], sent[4*w+3], 1'b0);
        checks++; if (got_le[w] !== e_le) begin errors++; $display("FAIL two_le_word%0d: got %08h want %08h", w, got_le[w], e_le); end
        checks++; if (got_be[w] !== e_be) begin errors++; $display("FAIL two_be_word%0d: got %08h want %08h", w, got_be[w], e_be); end
        checks++; if (got_last[w] !== (w == 1)) begin errors++; $display("FAIL two_last%0d: got %0b want %0b", w, got_last[w], (w == 1)); end
      end
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL two_fifo_empty: got %0b want 1", fifo_empty); end
  endtask

  task automatic test_refill();
    bit ok;
    rdy_mode = 1;
    clear_got();
    write_byte(8'h00); write_byte(8'h01);
    tick();
    issue_req(8'd1);
    repeat (20) tick();
    @(negedge rd_clk);
    checks++;
    if (le_busy !== 1'b1 || le_valid !== 1'b0 || got_le.size() != 0) begin
      errors++; $display("FAIL refill_stall: busy=%0b valid=%0b words=%0d want busy=1 valid=0 words=0", le_busy, le_valid, got_le.size());
    end
    tick();
    write_byte(8'h02); write_byte(8'h03);
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL refill_idle: busy timeout, want idle"); end
    checks++;
    if (got_le.size() != 1 || got_be.size() != 1) begin
      errors++; $display("FAIL refill_count: got %0d words want 1", got_le.size());
    end else begin
      checks++; if (got_le[0] !== 32'h03020100) begin errors++; $display("FAIL refill_le: got %08h want 03020100", got_le[0]); end
      checks++; if (got_be[0] !== 32'h00010203) begin errors++; $display("FAIL refill_be: got %08h want 00010203", got_be[0]); end
      checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL refill_last: got %0b want 1", got_last[0]); end
    end
  endtask

  task automatic test_sector();
    bit ok;
    rdy_mode = 1;
    clear_got();
    for (int i = 0; i < 512; i++) write_byte(8'($urandom));
    tick();
    rdy_mode = 2;
    issue_req(8'd128);
    wait_idle(8000, ok);
    rdy_mode = 1;
    checks++; if (!ok) begin errors++; $display("FAIL sector_idle: busy timeout, want idle"); end
    checks++;
    if (got_le.size() != 128 || got_be.size() != 128) begin
      errors++; $display("FAIL sector_count: got le=%0d be=%0d words want 128", got_le.size(), got_be.size());
    end else begin
      for (int w = 0; w < 128; w++) begin
        logic [31:0] e_le, e_be;
        e_le = pack(sent[4*w], sent[4*w+1], sent[4*w+2], sent[4*w+3], 1'b1);
        e_be = pack(sent[4*w], sent[4*w+1], sent[4*w+2], sent[4*w+3], 1'b0);
        checks++; if (got_le[w] !== e_le) begin errors++; $display("FAIL sector_le_word%0d: got %08h want %08h", w, got_le[w], e_le); end
        checks++; if (got_be[w] !== e_be) begin errors++; $display("FAIL sector_be_word%0d: got %08h want %08h", w, got_be[w], e_be); end
        checks++; if (got_last[w] !== (w == 127)) begin errors++; $display("FAIL sector_last%0d: got %0b want %0b", w, got_last[w], (w == 127)); end
      end
    end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL sector_fifo_empty: got %0b want 1", fifo_empty); end
  endtask

  task automatic test_zero_and_busy();
    bit ok;
    rdy_mode = 1;
    clear_got();
    rden_cnt = 0;
    issue_req(8'd0);
    repeat (5) tick();
    @(negedge rd_clk);
    checks++;
    if (le_busy !== 1'b0 || rden_cnt != 0 || got_le.size() != 0 || le_left !== 8'd0) begin
      errors++; $display("FAIL zero_req: busy=%0b pops=%0d words=%0d left=%0d want 0/0/0/0", le_busy, rden_cnt, got_le.size(), le_left);
    end
    tick();
    for (int i = 0; i < 4; i++) write_byte(8'hA0 + 8'(i));
    tick();
    issue_req(8'd1);
    req_valid = 1'b1; req_words = 8'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge rd_clk);
      checks++; if (le_req_ready !== 1'b0) begin errors++; $display("FAIL busy_req_ready: got %0b want 0", le_req_ready); end
      tick();
    end
    req_valid = 1'b0;
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_idle: busy timeout, want idle"); end
    repeat (3) tick();
    @(negedge rd_clk);
    checks++;
    if (got_le.size() != 1 || got_le[0] !== 32'hA3A2A1A0 || le_busy !== 1'b0 || le_left !== 8'd0) begin
      errors++; $display("FAIL busy_ignored: words=%0d first=%08h busy=%0b left=%0d want 1/a3a2a1a0/0/0",
                         got_le.size(), (got_le.size() > 0) ? got_le[0] : 32'h0, le_busy, le_left);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    bit ok;
    rdy_mode = 1;
    clear_got();
    write_byte(8'h11); write_byte(8'h22);
    tick();
    issue_req(8'd1);
    repeat (6) tick();
    @(negedge rd_clk);
    checks++; if (le_busy !== 1'b1 || le_valid !== 1'b0) begin errors++; $display("FAIL mid_pre: busy=%0b valid=%0b want 1/0", le_busy, le_valid); end
    tick();
    rd_rst = 1'b1;
    tick();
    @(negedge rd_clk);
    checks++;
    if (le_valid !== 1'b0 || le_data !== 32'h0 || le_last !== 1'b0 || le_left !== 8'd0 ||
        le_busy !== 1'b0 || le_rd_en !== 1'b0 || le_req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_rst_outputs: valid=%0b data=%08h last=%0b left=%0d busy=%0b rd_en=%0b rdy=%0b want reset values",
                         le_valid, le_data, le_last, le_left, le_busy, le_rd_en, le_req_ready);
    end
    tick();
    rd_rst = 1'b0;
    tick();
    clear_got();
    for (int i = 0; i < 4; i++) write_byte(8'h55 + 8'(17 * i));
    tick();
    issue_req(8'd1);
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_idle: busy timeout, want idle"); end
    checks++;
    if (got_le.size() != 1 || got_le[0] !== pack(sent[0], sent[1], sent[2], sent[3], 1'b1) ||
        got_be.size() != 1 || got_be[0] !== pack(sent[0], sent[1], sent[2], sent[3], 1'b0)) begin
      errors++; $display("FAIL mid_fresh_word: words=%0d le=%08h be=%08h want %08h/%08h", got_le.size(),
                         (got_le.size() > 0) ? got_le[0] : 32'h0, (got_be.size() > 0) ? got_be[0] : 32'h0,
                         pack(sent[0], sent[1], sent[2], sent[3], 1'b1), pack(sent[0], sent[1], sent[2], sent[3], 1'b0));
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_refill();
    test_sector();
    test_zero_and_busy();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
